// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
// The helper returns the unsigned magnitude of a two's complement word.
package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W = 6;
    localparam logic [31:0] OVF_CONST = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN,
        ST_RDY
    } state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_t;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// Shared add/subtract used by both the Booth and the restoring-division steps.
// Subtraction is done as a + ~b + 1 so a single adder serves both.
module multdiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    logic [W-1:0] b_eff;

    for (genvar gi = 0; gi < W; gi++) begin : g_inv
        assign b_eff[gi] = b[gi] ^ sub;
    end

    assign sum = a + b_eff + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply (radix-2 Booth) and divide (restoring),
// with a fixed 33-edge latency from start acceptance to the result-ready pulse.
module multdiv #(
    parameter int WIDTH = multdiv_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);

    import multdiv_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    op_t              op_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg, m_reg;
    logic             qm1_reg;
    logic             neg_reg, zero_div_reg, ovf_div_reg;
    logic [WIDTH-1:0] result_reg;
    logic             exc_reg;

    logic             accept;
    logic [WIDTH:0]   as_a, as_b, as_sum, booth_acc;
    logic             as_sub;
    logic [1:0]       booth_sel;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             qm1_next;
    logic [WIDTH-1:0] fin_result;
    logic             fin_exc;
    logic             product_fits;

    assign accept = (ctrl_MULT | ctrl_DIV) &&
                    (state_reg == ST_IDLE || state_reg == ST_RDY);

    always_ff @(posedge clock) begin
        if (ctrl_reset) state_reg <= ST_IDLE;
        else            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_RUN;
            ST_RUN:  if (cnt_reg == LAST_ITER) state_next = ST_FIN;
            ST_FIN:  state_next = ST_RDY;
            ST_RDY:  state_next = accept ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        data_busy      = 1'b0;
        data_resultRDY = 1'b0;
        case (state_reg)
            ST_RUN, ST_FIN: data_busy = 1'b1;
            ST_RDY:         data_resultRDY = 1'b1;
            default: ;
        endcase
    end

    multdiv_addsub #(.W(WIDTH + 1)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .sum (as_sum)
    );

    // Booth works on sign-extended hi; division shifts the next dividend bit into the remainder.
    assign booth_sel = {lo_reg[0], qm1_reg};

    always_comb begin
        as_a      = {hi_reg[WIDTH-1], hi_reg};
        as_b      = {m_reg[WIDTH-1], m_reg};
        as_sub    = (booth_sel == 2'b10);
        booth_acc = as_sum;
        hi_next   = hi_reg;
        lo_next   = lo_reg;
        qm1_next  = qm1_reg;
        if (op_reg == OP_MULT) begin
            if (booth_sel[1] == booth_sel[0]) booth_acc = as_a;
            hi_next  = booth_acc[WIDTH:1];
            lo_next  = {booth_acc[0], lo_reg[WIDTH-1:1]};
            qm1_next = lo_reg[0];
        end else begin
            as_a   = {hi_reg, lo_reg[WIDTH-1]};
            as_b   = {1'b0, m_reg};
            as_sub = 1'b1;
            // The trial difference always lies within 33-bit signed range, so its sign decides.
            if (!as_sum[WIDTH]) begin
                hi_next = as_sum[WIDTH-1:0];
                lo_next = {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = as_a[WIDTH-1:0];
                lo_next = {lo_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign product_fits = (&{hi_reg, lo_reg[WIDTH-1]}) | ~(|{hi_reg, lo_reg[WIDTH-1]});

    always_comb begin
        fin_result = lo_reg;
        fin_exc    = ~product_fits;
        if (op_reg == OP_DIV) begin
            if (zero_div_reg) begin
                fin_result = '0;
                fin_exc    = 1'b1;
            end else begin
                fin_result = neg_reg ? (~lo_reg + 1'b1) : lo_reg;
                fin_exc    = ovf_div_reg;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            cnt_reg      <= '0;
            op_reg       <= OP_MULT;
            hi_reg       <= '0;
            lo_reg       <= '0;
            m_reg        <= '0;
            qm1_reg      <= 1'b0;
            neg_reg      <= 1'b0;
            zero_div_reg <= 1'b0;
            ovf_div_reg  <= 1'b0;
            result_reg   <= '0;
            exc_reg      <= 1'b0;
        end else begin
            if (accept) begin
                cnt_reg      <= '0;
                op_reg       <= ctrl_MULT ? OP_MULT : OP_DIV;
                hi_reg       <= '0;
                qm1_reg      <= 1'b0;
                lo_reg       <= ctrl_MULT ? data_operandA : magnitude(data_operandA);
                m_reg        <= ctrl_MULT ? data_operandB : magnitude(data_operandB);
                neg_reg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                zero_div_reg <= (data_operandB == '0);
                ovf_div_reg  <= (data_operandA == OVF_CONST) && (&data_operandB);
            end else if (state_reg == ST_RUN) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
                hi_reg  <= hi_next;
                lo_reg  <= lo_next;
                qm1_reg <= qm1_next;
            end
            if (state_reg == ST_FIN) begin
                result_reg <= fin_result;
                exc_reg    <= fin_exc;
            end
        end
    end

    assign data_result    = result_reg;
    assign data_exception = exc_reg;

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: vector table plus random ops against a
// behavioural model, and hand sequences for reset, abort and back-to-back starts.
module tb_multdiv;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        data_busy;

    always #5 clock = ~clock;

    multdiv #(.WIDTH(32)) dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .data_busy      (data_busy)
    );

    typedef struct {
        bit          is_mult;
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[15];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    function automatic void model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) begin
            p = sa * sb;
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = 1'b0;
        end
    endfunction

    // Call just after a negedge: drives a one-cycle start accepted on the next posedge.
    task automatic drive_start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic exc);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        sb_q.push_back('{res, exc});
    endtask

    task automatic clear_start();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Entered at the negedge sample following edge t<start_k>; returns at the resultRDY sample.
    task automatic wait_result(input string name, input int start_k);
        int   k;
        bit   busy_ok;
        exp_t e;
        k = start_k;
        busy_ok = 1'b1;
        while (!data_resultRDY && k < 60) begin
            if (!data_busy) busy_ok = 1'b0;
            @(negedge clock);
            k++;
        end
        check1({name, " busy_window"}, busy_ok, 1'b1);
        check32({name, " latency"}, 32'(k), 32'd33);
        check1({name, " busy_at_rdy"}, data_busy, 1'b0);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: resultRDY seen with empty scoreboard", name);
        end else begin
            e = sb_q.pop_front();
            check32({name, " result"}, data_result, e.res);
            check1({name, " exception"}, data_exception, e.exc);
            $display("op %s: result=%h exc=%b latency=%0d", name, data_result, data_exception, k);
        end
    endtask

    task automatic post_check(input string name, input logic [31:0] res);
        @(negedge clock);
        check1({name, " rdy_pulse_end"}, data_resultRDY, 1'b0);
        check32({name, " result_hold"}, data_result, res);
    endtask

    task automatic run_op(input string name, input bit m, input bit d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic exc);
        @(negedge clock);
        drive_start(m, d, a, b, res, exc);
        @(negedge clock);
        clear_start();
        wait_result(name, 0);
        post_check(name, res);
    endtask

    task automatic expect_no_rdy(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (data_resultRDY) seen = 1'b1;
            @(negedge clock);
        end
        check1({name, " no_rdy"}, seen, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb, rr;
        logic        re;
        bit          rm;

        vecs[0]  = '{1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[2]  = '{1, 0, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0};
        vecs[3]  = '{0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{0, 1, 32'd7,          32'd0,         32'h0000_0000, 1'b1};
        vecs[5]  = '{0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[6]  = '{1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[7]  = '{1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[8]  = '{0, 1, 32'd100,        32'd7,         32'd14,        1'b0};
        vecs[9]  = '{0, 1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        1'b0};
        vecs[10] = '{0, 1, 32'd7,          32'hFFFF_FF9C, 32'd0,         1'b0};
        vecs[11] = '{1, 0, 32'h1234_5678,  32'h0000_0100, 32'h3456_7800, 1'b1};
        vecs[12] = '{1, 0, 32'hFFFF_0000,  32'h0000_8000, 32'h8000_0000, 1'b0};
        vecs[13] = '{0, 1, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0};
        vecs[14] = '{0, 1, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'd1,         1'b0};

        ctrl_reset    = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check32("reset result", data_result, 32'd0);
        check1("reset exception", data_exception, 1'b0);
        check1("reset rdy", data_resultRDY, 1'b0);
        check1("reset busy", data_busy, 1'b0);
        ctrl_reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].is_mult, vecs[i].is_div,
                   vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);
        end

        for (int i = 0; i < 20; i++) begin
            rm = $urandom_range(0, 1) == 1;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) ra = {{16{ra[15]}}, ra[15:0]};
            if ($urandom_range(0, 1) == 1) rb = {{24{rb[7]}}, rb[7:0]};
            model(rm, ra, rb, rr, re);
            run_op($sformatf("rnd%0d %s %h %h", i, rm ? "mul" : "div", ra, rb), rm, !rm, ra, rb, rr, re);
        end

        // Abort at iteration 10 after a nonzero result so the reset clear is visible.
        run_op("pre_abort", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0);
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(negedge clock);
        clear_start();
        repeat (10) @(negedge clock);
        ctrl_reset = 1'b1;
        @(negedge clock);
        ctrl_reset = 1'b0;
        check1("abort busy", data_busy, 1'b0);
        check32("abort result", data_result, 32'd0);
        check1("abort exception", data_exception, 1'b0);
        check1("abort rdy", data_resultRDY, 1'b0);
        expect_no_rdy("abort", 40);
        $display("op abort: reset at iteration 10");
        run_op("post_abort 5x6", 1'b1, 1'b0, 32'd5, 32'd6, 32'd30, 1'b0);

        // Reset wins over a simultaneous start.
        @(negedge clock);
        ctrl_reset    = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        @(negedge clock);
        ctrl_reset = 1'b0;
        clear_start();
        check1("reset_start busy", data_busy, 1'b0);
        expect_no_rdy("reset_start", 40);
        $display("op reset_start: start dropped");

        // Both starts high -> MULT; DIV pulse mid-run ignored; back-to-back start in RDY cycle.
        @(negedge clock);
        ctrl_DIV = 1'b1;
        drive_start(1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);
        @(negedge clock);
        clear_start();
        repeat (5) @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(negedge clock);
        clear_start();
        wait_result("both_high 6x3", 6);
        drive_start(1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0);
        @(negedge clock);
        clear_start();
        wait_result("b2b 100/7", 0);
        post_check("b2b 100/7", 32'd14);

        check32("scoreboard empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
